// File: rtl/operand_conv_arbiter.sv
// Two-requester round-robin arbiter feeding a sign/magnitude converter with a
// single output register; width-mode changes drain the output before taking effect.
module operand_conv_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_width,
    input  logic        cfg_we,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [15:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [15:0] b_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_mag,
    output logic [1:0]  out_sign,
    output logic        out_src,
    output logic        cur_width
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        rr_ptr_r;
    logic        cur_width_r;
    logic        width_nxt_s;
    logic        pending_r;
    logic        pending_nxt_s;
    logic        out_valid_r;
    logic [15:0] out_mag_r;
    logic [1:0]  out_sign_r;
    logic        out_src_r;
    logic        slot_free_s;
    logic        cfg_change_s;
    logic        grant_ok_s;
    logic        grant_a_s;
    logic        grant_b_s;
    logic [15:0] sel_data_s;
    logic [17:0] conv_s;

    // Two's-complement magnitude; the most negative value maps onto itself.
    function automatic logic [15:0] abs16(input logic [15:0] d);
        abs16 = d[15] ? (16'd0 - d) : d;
    endfunction

    function automatic logic [7:0] abs8(input logic [7:0] d);
        abs8 = d[7] ? (8'd0 - d) : d;
    endfunction

    // Returns {sign[1:0], mag[15:0]} for the given width mode.
    function automatic logic [17:0] convert(input logic [15:0] d, input logic w);
        if (w) begin
            convert = {d[15], d[7], abs8(d[15:8]), abs8(d[7:0])};
        end else begin
            convert = {d[15], 1'b0, abs16(d)};
        end
    endfunction

    assign slot_free_s  = !out_valid_r || out_ready;
    assign cfg_change_s = cfg_we && (cfg_width != cur_width_r);

    // Mode FSM: decides whether grants are allowed and when a pending width lands.
    always_comb begin
        state_nxt_s   = state_r;
        pending_nxt_s = pending_r;
        width_nxt_s   = cur_width_r;
        grant_ok_s    = 1'b0;
        case (state_r)
            RUN: begin
                if (cfg_change_s) begin
                    pending_nxt_s = cfg_width;
                    state_nxt_s   = DRAIN;
                end else begin
                    grant_ok_s = slot_free_s;
                end
            end
            DRAIN: begin
                if (cfg_we) begin
                    pending_nxt_s = cfg_width;
                end else begin
                    pending_nxt_s = pending_r;
                end
                if (slot_free_s) begin
                    width_nxt_s = pending_nxt_s;
                    state_nxt_s = RUN;
                end else begin
                    width_nxt_s = cur_width_r;
                end
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // Pointer names the requester favoured on contention.
    assign grant_a_s  = rst_n && grant_ok_s && a_valid && (!b_valid || (rr_ptr_r == 1'b0));
    assign grant_b_s  = rst_n && grant_ok_s && b_valid && (!a_valid || (rr_ptr_r == 1'b1));
    assign a_ready    = grant_a_s;
    assign b_ready    = grant_b_s;
    assign sel_data_s = grant_b_s ? b_data : a_data;
    assign conv_s     = convert(sel_data_s, cur_width_r);

    // Control state: FSM, width mode, pending width and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RUN;
            cur_width_r <= 1'b0;
            pending_r   <= 1'b0;
            rr_ptr_r    <= RR_INIT;
        end else begin
            state_r     <= state_nxt_s;
            cur_width_r <= width_nxt_s;
            pending_r   <= pending_nxt_s;
            if (grant_a_s) begin
                rr_ptr_r <= 1'b1;
            end else if (grant_b_s) begin
                rr_ptr_r <= 1'b0;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Output register: loads on acceptance, empties when consumed, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_mag_r   <= 16'd0;
            out_sign_r  <= 2'b00;
            out_src_r   <= 1'b0;
        end else if (grant_a_s || grant_b_s) begin
            out_valid_r <= 1'b1;
            out_mag_r   <= conv_s[15:0];
            out_sign_r  <= conv_s[17:16];
            out_src_r   <= grant_b_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_mag   = out_mag_r;
    assign out_sign  = out_sign_r;
    assign out_src   = out_src_r;
    assign cur_width = cur_width_r;

endmodule

// File: tb/tb_operand_conv_arbiter.sv
// Scoreboard bench for operand_conv_arbiter: drivers queue hand-computed results
// per requester, an acceptance watcher orders them, a monitor compares outputs.
module tb_operand_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, cfg_width, cfg_we;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [15:0] a_data, b_data;
    logic        out_valid, out_ready, out_src, cur_width;
    logic [15:0] out_mag;
    logic [1:0]  out_sign;

    typedef struct packed {
        logic        src;
        logic [1:0]  sign;
        logic [15:0] mag;
    } exp_t;

    exp_t exp_a_q[$];
    exp_t exp_b_q[$];
    exp_t sb_q[$];
    logic grant_log[$];
    int   total = 0;
    int   bad   = 0;
    time  t0;

    always #5 clk = ~clk;

    operand_conv_arbiter #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_width(cfg_width), .cfg_we(cfg_we),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mag(out_mag),
        .out_sign(out_sign), .out_src(out_src), .cur_width(cur_width)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge, valid left high.
    task automatic send_a(input logic [15:0] d, input logic [15:0] mag, input logic [1:0] sign);
        bit done = 1'b0;
        exp_a_q.push_back('{1'b0, sign, mag});
        a_data  = d;
        a_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (a_ready) done = 1'b1;
        end
        if (done) begin
            tick();
        end else begin
            chk("send_a_timeout", 32'd0, 32'd1);
            a_valid = 1'b0;
            void'(exp_a_q.pop_back());
        end
    endtask

    task automatic send_b(input logic [15:0] d, input logic [15:0] mag, input logic [1:0] sign);
        bit done = 1'b0;
        exp_b_q.push_back('{1'b1, sign, mag});
        b_data  = d;
        b_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (b_ready) done = 1'b1;
        end
        if (done) begin
            tick();
        end else begin
            chk("send_b_timeout", 32'd0, 32'd1);
            b_valid = 1'b0;
            void'(exp_b_q.pop_back());
        end
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        tick();
    endtask

    // Acceptance watcher: moves the accepted requester's expectation into output order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_ready && b_ready) chk("ready_exclusive", 32'd1, 32'd0);
            if (a_valid && a_ready) begin
                if (exp_a_q.size() == 0) chk("unexpected_a_grant", 32'd1, 32'd0);
                else begin
                    sb_q.push_back(exp_a_q.pop_front());
                    grant_log.push_back(1'b0);
                end
            end
            if (b_valid && b_ready) begin
                if (exp_b_q.size() == 0) chk("unexpected_b_grant", 32'd1, 32'd0);
                else begin
                    sb_q.push_back(exp_b_q.pop_front());
                    grant_log.push_back(1'b1);
                end
            end
        end
    end

    // Output monitor: compares each consumed result against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
            else begin
                e = sb_q.pop_front();
                chk("out_mag", out_mag, e.mag);
                chk("out_sign", out_sign, e.sign);
                chk("out_src", out_src, e.src);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfg_width = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; a_data = 16'h1234; b_data = 16'h5678;
        #12;
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_a_ready", a_ready, 32'd0);
        chk("rst_b_ready", b_ready, 32'd0);
        chk("rst_out_mag", out_mag, 32'd0);
        chk("rst_out_sign", out_sign, 32'd0);
        chk("rst_out_src", out_src, 32'd0);
        chk("rst_cur_width", cur_width, 32'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Contention: A and B valid throughout, expect A,B,A,B,... one per cycle.
        grant_log.delete();
        t0 = $time;
        fork
            begin
                send_a(16'h0005, 16'h0005, 2'b00);
                send_a(16'hFFFB, 16'h0005, 2'b10);
                send_a(16'h8000, 16'h8000, 2'b10);
                send_a(16'h7FFF, 16'h7FFF, 2'b00);
                a_valid = 1'b0;
            end
            begin
                send_b(16'hFFFE, 16'h0002, 2'b10);
                send_b(16'h0000, 16'h0000, 2'b00);
                send_b(16'hFF00, 16'h0100, 2'b10);
                send_b(16'h1234, 16'h1234, 2'b00);
                b_valid = 1'b0;
            end
        join
        chk("contention_cycles", 32'($time - t0), 32'd80);
        chk("contention_grants", grant_log.size(), 32'd8);
        for (int i = 0; i < grant_log.size(); i++) chk("rr_order", grant_log[i], i % 2);
        wait_empty();

        // Single requester, latency one cycle.
        send_a(16'hFFFE, 16'h0002, 2'b10);
        a_valid = 1'b0;
        @(negedge clk);
        chk("lat_out_valid", out_valid, 32'd1);
        chk("lat_out_mag", out_mag, 32'h0002);
        chk("lat_out_sign", out_sign, 32'd2);
        chk("lat_out_src", out_src, 32'd0);
        wait_empty();

        // Stall three cycles, then the waiting B is granted on the release cycle.
        out_ready = 1'b0;
        send_a(16'h0003, 16'h0003, 2'b00);
        a_valid = 1'b0;
        fork
            send_b(16'hFFFF, 16'h0001, 2'b10);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_a_ready", a_ready, 32'd0);
                    chk("stall_b_ready", b_ready, 32'd0);
                    chk("stall_valid", out_valid, 32'd1);
                    chk("stall_mag", out_mag, 32'h0003);
                    chk("stall_sign", out_sign, 32'd0);
                    chk("stall_src", out_src, 32'd0);
                end
                tick();
                out_ready = 1'b1;
                @(negedge clk);
                chk("release_b_ready", b_ready, 32'd1);
            end
        join
        b_valid = 1'b0;
        wait_empty();

        // Width change while stalled: no grants until drained, width lands on drain edge.
        out_ready = 1'b0;
        send_a(16'h0010, 16'h0010, 2'b00);
        a_valid = 1'b0;
        fork
            send_b(16'h80FF, 16'h8001, 2'b11);
            begin
                cfg_we = 1'b1; cfg_width = 1'b1;
                @(negedge clk);
                chk("cfg_cycle_b_ready", b_ready, 32'd0);
                tick();
                cfg_we = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("drain_b_ready", b_ready, 32'd0);
                    chk("drain_width_old", cur_width, 32'd0);
                end
                tick();
                out_ready = 1'b1;
                @(negedge clk);
                chk("drain_edge_b_ready", b_ready, 32'd0);
                chk("drain_edge_width", cur_width, 32'd0);
                @(negedge clk);
                chk("new_width", cur_width, 32'd1);
                chk("post_drain_b_ready", b_ready, 32'd1);
            end
        join
        b_valid = 1'b0;
        wait_empty();

        // Same-value cfg_we is ignored: grant proceeds in that cycle.
        fork
            send_a(16'h8080, 16'h8080, 2'b11);
            begin
                cfg_we = 1'b1; cfg_width = 1'b1;
                @(negedge clk);
                chk("same_width_grant", a_ready, 32'd1);
                tick();
                cfg_we = 1'b0;
            end
        join
        a_valid = 1'b0;
        send_b(16'h7F81, 16'h7F7F, 2'b01);
        b_valid = 1'b0;
        wait_empty();

        // Back to 16-bit with an empty output register.
        fork
            send_a(16'hFFFB, 16'h0005, 2'b10);
            begin
                cfg_we = 1'b1; cfg_width = 1'b0;
                @(negedge clk);
                chk("cfg_cycle_a_ready", a_ready, 32'd0);
                tick();
                cfg_we = 1'b0;
                @(negedge clk);
                chk("drain_empty_a_ready", a_ready, 32'd0);
                chk("drain_empty_width", cur_width, 32'd1);
                @(negedge clk);
                chk("back_width", cur_width, 32'd0);
                chk("back_a_ready", a_ready, 32'd1);
            end
        join
        a_valid = 1'b0;
        wait_empty();

        // Reset mid-transfer discards the held result; first grant follows RR_INIT.
        out_ready = 1'b0;
        send_a(16'h0042, 16'h0042, 2'b00);
        a_valid = 1'b0;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("mid_rst_valid", out_valid, 32'd0);
        chk("mid_rst_mag", out_mag, 32'd0);
        chk("mid_rst_sign", out_sign, 32'd0);
        chk("mid_rst_src", out_src, 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        grant_log.delete();
        fork
            begin send_a(16'h0001, 16'h0001, 2'b00); a_valid = 1'b0; end
            begin send_b(16'h0002, 16'h0002, 2'b00); b_valid = 1'b0; end
        join
        chk("post_rst_grants", grant_log.size(), 32'd2);
        if (grant_log.size() == 2) begin
            chk("post_rst_first", grant_log[0], 32'd0);
            chk("post_rst_second", grant_log[1], 32'd1);
        end
        wait_empty();
        chk("a_queue_empty", exp_a_q.size(), 32'd0);
        chk("b_queue_empty", exp_b_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
